// File: rtl/bus_write_unit_if.sv
// rtl/bus_write_unit_if.sv - bus-side and data-memory-side signals of bus_write_unit
//
// Ports (slave = bus_write_unit, master = the bus/memory environment):
//   write_en [3:0]   destination select code (mirrors bus read_en codes)
//   busin    [N-1:0] bus value to be written; only bits [11:0] are stored
//   pc_inc           increment pc by 1
//   dm_ack           data memory write-complete pulse
//   dm_addr  [11:0]  data memory write address
//   dm_wdata [11:0]  data memory write data
//   dm_we            single-cycle data memory write strobe
//   busy             a data memory write is outstanding
interface bus_write_unit_if #(
  parameter int N = 17
) ();

  logic [3:0]   write_en;
  logic [N-1:0] busin;
  logic         pc_inc;
  logic         dm_ack;
  logic [11:0]  dm_addr;
  logic [11:0]  dm_wdata;
  logic         dm_we;
  logic         busy;

  modport slave (
    input  write_en,
    input  busin,
    input  pc_inc,
    input  dm_ack,
    output dm_addr,
    output dm_wdata,
    output dm_we,
    output busy
  );

  modport master (
    output write_en,
    output busin,
    output pc_inc,
    output dm_ack,
    input  dm_addr,
    input  dm_wdata,
    input  dm_we,
    input  busy
  );

endinterface

// File: rtl/bus_write_unit.sv
// rtl/bus_write_unit.sv - decodes bus writes into architectural registers and data memory
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   bus             bus_write_unit_if.slave (write_en, busin, pc_inc, dm_ack in;
//                   dm_addr, dm_wdata, dm_we, busy out)
//   r1..r4, ir, ac  architectural registers (12 bits)
//   ar              data address register (12 bits)
//   pc              instruction address register (12 bits)
module bus_write_unit #(
  parameter int N = 17
) (
  input  logic              clk,
  input  logic              rst,
  bus_write_unit_if.slave   bus,
  output logic [11:0]       r1,
  output logic [11:0]       r2,
  output logic [11:0]       r3,
  output logic [11:0]       r4,
  output logic [11:0]       ir,
  output logic [11:0]       ac,
  output logic [11:0]       ar,
  output logic [11:0]       pc
);

  localparam logic [3:0] WE_AR  = 4'd1;
  localparam logic [3:0] WE_PC  = 4'd2;
  localparam logic [3:0] WE_IR  = 4'd4;
  localparam logic [3:0] WE_AC  = 4'd5;
  localparam logic [3:0] WE_R1  = 4'd7;
  localparam logic [3:0] WE_R2  = 4'd8;
  localparam logic [3:0] WE_R3  = 4'd9;
  localparam logic [3:0] WE_R4  = 4'd10;
  localparam logic [3:0] WE_MEM = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2
  } dm_state_e;

  dm_state_e   state_q, state_d;
  logic [11:0] r1_q, r1_d;
  logic [11:0] r2_q, r2_d;
  logic [11:0] r3_q, r3_d;
  logic [11:0] r4_q, r4_d;
  logic [11:0] ir_q, ir_d;
  logic [11:0] ac_q, ac_d;
  logic [11:0] ar_q, ar_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] dm_addr_q, dm_addr_d;
  logic [11:0] dm_wdata_q, dm_wdata_d;
  logic        dm_we_q, dm_we_d;
  logic        busy_q, busy_d;

  logic [11:0] bus12;
  logic        wr_open;
  logic        pc_load;

  assign bus12 = bus.busin[11:0];

  // Upper bus bits carry nothing this unit stores.
  generate
    if (N > 12) begin : g_hi
      logic unused_busin_hi;
      assign unused_busin_hi = ^bus.busin[N-1:12];
    end
  endgenerate

  // Writes are only accepted while no memory write is outstanding.
  assign wr_open = (state_q == S_IDLE);
  assign pc_load = wr_open && (bus.write_en == WE_PC);

  always_comb begin
    r1_d       = r1_q;
    r2_d       = r2_q;
    r3_d       = r3_q;
    r4_d       = r4_q;
    ir_d       = ir_q;
    ac_d       = ac_q;
    ar_d       = ar_q;
    pc_d       = pc_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_we_d    = 1'b0;
    busy_d     = busy_q;
    state_d    = state_q;

    if (wr_open) begin
      case (bus.write_en)
        WE_AR:   ar_d = bus12;
        WE_PC:   pc_d = bus12;
        WE_IR:   ir_d = bus12;
        WE_AC:   ac_d = bus12;
        WE_R1:   r1_d = bus12;
        WE_R2:   r2_d = bus12;
        WE_R3:   r3_d = bus12;
        WE_R4:   r4_d = bus12;
        WE_MEM: begin
          // Address is ar as it stands before this edge.
          dm_addr_d  = ar_q;
          dm_wdata_d = bus12;
          dm_we_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_STROBE;
        end
        default: ;
      endcase
    end

    // A bus load of pc wins over the increment on the same edge.
    if (bus.pc_inc && !pc_load) begin
      pc_d = pc_q + 12'd1;
    end

    case (state_q)
      S_STROBE: begin
        busy_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.dm_ack) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      r4_q       <= '0;
      ir_q       <= '0;
      ac_q       <= '0;
      ar_q       <= '0;
      pc_q       <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      r3_q       <= r3_d;
      r4_q       <= r4_d;
      ir_q       <= ir_d;
      ac_q       <= ac_d;
      ar_q       <= ar_d;
      pc_q       <= pc_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_we_q    <= dm_we_d;
      busy_q     <= busy_d;
      state_q    <= state_d;
    end
  end

  assign r1 = r1_q;
  assign r2 = r2_q;
  assign r3 = r3_q;
  assign r4 = r4_q;
  assign ir = ir_q;
  assign ac = ac_q;
  assign ar = ar_q;
  assign pc = pc_q;

  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/bus_write_unit.md
BUS_WRITE_UNIT -- requirements
Module: bus_write_unit

Interface
REQ-001 SHALL have parameter N, default 17: bus width in bits; legal range N >= 12.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port write_en  input  4  destination select code; codes mirror bus read_en codes.
REQ-005 SHALL have port busin  input  N  bus value to be written.
REQ-006 SHALL have port pc_inc  input  1  increment pc by 1.
REQ-007 SHALL have port dm_ack  input  1  data memory write-complete pulse.
REQ-008 SHALL have ports r1, r2, r3, r4, ir, ac  output  12 each  architectural registers.
REQ-009 SHALL have ports ar (data address) and pc (instruction address)  output  12 each.
REQ-010 SHALL have port dm_addr  output  12  data memory write address.
REQ-011 SHALL have port dm_wdata  output  12  data memory write data.
REQ-012 SHALL have port dm_we  output  1  single-cycle data memory write strobe.
REQ-013 SHALL have port busy  output  1  high while a data memory write is outstanding.

Function
REQ-014 SHALL decode write_en: 1=ar, 2=pc, 4=ir, 5=ac, 7=r1, 8=r2, 9=r3, 10=r4, 12=data memory; all other codes (0, 3, 6, 11, 13, 14, 15) write nothing.
REQ-015 SHALL load busin[11:0] into the selected register on the rising edge where write_en selects it; busin[N-1:12] are discarded.
REQ-016 SHALL have register write latency of 1 cycle: the new value is visible on the output the cycle after the edge.
REQ-017 SHALL leave all unselected registers unchanged.
REQ-018 SHALL increment pc modulo 4096 when pc_inc=1 (4095 -> 0).
REQ-019 SHALL give write_en=2 priority over pc_inc on the same edge: pc takes busin[11:0], no increment.
REQ-020 SHALL implement the data memory FSM as IDLE -> STROBE -> WAIT -> IDLE.
REQ-021 IDLE: on write_en=12, SHALL capture dm_wdata=busin[11:0] and dm_addr=ar (value before this edge), then go to STROBE.
REQ-022 STROBE: SHALL assert dm_we=1 for exactly this one cycle, then go to WAIT.
REQ-023 WAIT: SHALL stay until dm_ack=1, then return to IDLE on that edge.
REQ-024 SHALL drive busy=1 in STROBE and WAIT, and busy=0 in IDLE.
REQ-025 SHALL ignore every write_en code while busy=1; pc_inc SHALL still be honoured.
REQ-026 SHALL ignore dm_ack in IDLE and STROBE.
REQ-027 SHALL hold dm_addr and dm_wdata stable from STROBE until the return to IDLE.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, clear r1–r4, ir, ac, ar, pc, dm_addr and dm_wdata to 0, set dm_we=0 and busy=0, and put the FSM in IDLE.
REQ-029 SHALL give rst priority over write_en, pc_inc and dm_ack on the same edge.
REQ-030 SHALL abandon an outstanding memory write on reset mid-transaction, with no dm_we afterwards.

Verification
REQ-031 SHALL pass: reset, then write_en=7 with busin=17'h1_0ABC for 1 cycle -> next cycle r1=12'hABC, all other registers 0.
REQ-032 SHALL pass: pc=12'hFFF, pc_inc=1 -> pc=0; then write_en=2, busin=12'h123 and pc_inc=1 on the same edge -> pc=12'h123.
REQ-033 SHALL pass: ar=12'h040, write_en=12, busin=12'h5A5 -> dm_we high exactly 1 cycle with dm_addr=040 and dm_wdata=5A5; busy high until dm_ack; busy low the cycle after the dm_ack edge.
REQ-034 SHALL pass: during WAIT, write_en=5, busin=12'h777 -> ac unchanged; dm_ack in IDLE -> no state change.
REQ-035 SHALL pass: write_en in {0, 3, 6, 11, 13, 14, 15} with busin=12'hFFF -> no register changes and busy stays 0.
REQ-036 SHALL pass: rst asserted in WAIT -> busy=0 and all registers 0 next cycle; a later dm_ack produces no effect.
